edge_detect_filt: RTL and testbench

- Multi-channel, parametrised successor to the team's single-purpose rising-edge macro.
- Per channel, the block:
  - synchronises an asynchronous input;
  - debounces it with a programmable stability filter;
  - emits registered single-cycle rise, fall and any-edge pulses, each gated by a per-channel mode enable;
  - keeps a sticky event flag with software clear.
- Sits between raw pins or cross-domain status lines and control logic or interrupt aggregation.

---
 rtl/edge_detect_filt_if.sv | 26 ++
 rtl/edge_detect_filt.sv | 79 +++++++
 tb/tb_edge_detect_filt.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/edge_detect_filt_if.sv
// Bundle of per-channel pin inputs, mode/clear controls and filtered edge outputs.
// The slave side is the filter block; the master side is whatever drives the pins and reads results.
interface edge_detect_filt_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] signal;
   logic [WIDTH-1:0] mode_rise;
   logic [WIDTH-1:0] mode_fall;
   logic [WIDTH-1:0] flag_clr;
   logic [WIDTH-1:0] o_level;
   logic [WIDTH-1:0] o_rise;
   logic [WIDTH-1:0] o_fall;
   logic [WIDTH-1:0] o_edge;
   logic [WIDTH-1:0] o_flag;
   logic             o_any;

   modport master (
      output signal, mode_rise, mode_fall, flag_clr,
      input  o_level, o_rise, o_fall, o_edge, o_flag, o_any
   );

   modport slave (
      input  signal, mode_rise, mode_fall, flag_clr,
      output o_level, o_rise, o_fall, o_edge, o_flag, o_any
   );
endinterface

// File: rtl/edge_detect_filt.sv
// Per-channel synchroniser + stability filter + registered rise/fall pulses and sticky flags.
// Latency SYNC_STAGES+FILT_LEN edges from a stable input to o_level/pulse; no backpressure, pulses are fire-and-forget.
module edge_detect_filt #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   edge_detect_filt_if.slave bus
);
   localparam int              CW      = $clog2(FILT_LEN) + 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q [WIDTH];
   logic [SYNC_STAGES-1:0] sync_d [WIDTH];
   logic [CW-1:0]          cnt_q  [WIDTH];
   logic [CW-1:0]          cnt_d  [WIDTH];

   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] flag_q, flag_d;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] accept;

   always_comb begin
      s       = '0;
      accept  = '0;
      level_d = level_q;
      for (int i = 0; i < WIDTH; i++) begin
         sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], bus.signal[i]};
         s[i]      = sync_q[i][SYNC_STAGES-1];
         cnt_d[i]  = '0;
         // Any return to the current level before acceptance restarts the count.
         if (s[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               accept[i]  = 1'b1;
               level_d[i] = s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      rise_d = accept & s & bus.mode_rise;
      fall_d = accept & ~s & bus.mode_fall;
      // A new edge outranks a simultaneous clear.
      flag_d = (flag_q & ~bus.flag_clr) | rise_d | fall_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            sync_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         flag_q  <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            sync_q[i] <= sync_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         flag_q  <= flag_d;
      end
   end

   assign bus.o_level = level_q;
   assign bus.o_rise  = rise_q;
   assign bus.o_fall  = fall_q;
   assign bus.o_edge  = rise_q | fall_q;
   assign bus.o_flag  = flag_q;
   assign bus.o_any   = |flag_q;
endmodule

// File: tb/tb_edge_detect_filt.sv
// Directed and randomized bench for edge_detect_filt against a sample-window reference model.
module tb_edge_detect_filt;
   localparam int W = 8;
   localparam int S = 2;
   localparam int F = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model: raw input samples, newest first; filter input at edge n is the sample from edge n-S.
   logic [W-1:0] hist [$];
   logic [W-1:0] m_level, m_rise, m_fall, m_flag;

   edge_detect_filt_if #(.WIDTH(W)) bus ();

   edge_detect_filt #(.WIDTH(W), .SYNC_STAGES(S), .FILT_LEN(F)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < S + F; i++) hist.push_back('0);
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_flag  = '0;
   endtask

   // A change is accepted when the last F filter inputs all differ from the current level.
   task automatic model_step();
      logic [W-1:0] sv, acc;
      logic         all_diff;
      hist.push_front(bus.signal);
      void'(hist.pop_back());
      sv  = hist[S];
      acc = '0;
      for (int c = 0; c < W; c++) begin
         all_diff = 1'b1;
         for (int j = 0; j < F; j++)
            if (hist[S+j][c] == m_level[c]) all_diff = 1'b0;
         acc[c] = all_diff;
      end
      m_rise  = acc & sv & bus.mode_rise;
      m_fall  = acc & ~sv & bus.mode_fall;
      m_level = (m_level & ~acc) | (sv & acc);
      m_flag  = (m_flag & ~bus.flag_clr) | m_rise | m_fall;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_level"}, 32'(bus.o_level), 32'(m_level));
      check({tag, "_rise"},  32'(bus.o_rise),  32'(m_rise));
      check({tag, "_fall"},  32'(bus.o_fall),  32'(m_fall));
      check({tag, "_edge"},  32'(bus.o_edge),  32'(m_rise | m_fall));
      check({tag, "_flag"},  32'(bus.o_flag),  32'(m_flag));
      check({tag, "_any"},   32'(bus.o_any),   32'(|m_flag));
   endtask

   // One clock: model follows the active edge, outputs compared on the falling edge.
   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_level"}, 32'(bus.o_level), 32'h0);
      check({tag, "_rise"},  32'(bus.o_rise),  32'h0);
      check({tag, "_fall"},  32'(bus.o_fall),  32'h0);
      check({tag, "_edge"},  32'(bus.o_edge),  32'h0);
      check({tag, "_flag"},  32'(bus.o_flag),  32'h0);
      check({tag, "_any"},   32'(bus.o_any),   32'h0);
   endtask

   initial begin
      int           rise_at, rise_cnt, fall_cnt, hit;
      logic [W-1:0] mask;

      rst_n         = 1'b0;
      bus.signal    = '0;
      bus.mode_rise = 8'hFB;
      bus.mode_fall = 8'hFF;
      bus.flag_clr  = '0;
      model_reset();
      #1;
      check_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cycle("idle");

      // ch0 rise: pulse exactly once, SYNC_STAGES+FILT_LEN edges after the first sampling edge
      bus.signal[0] = 1'b1;
      rise_at  = 0;
      rise_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         cycle("ch0");
         if (bus.o_rise[0]) begin
            rise_cnt++;
            rise_at = i;
            check("ch0_level_with_pulse", 32'(bus.o_level[0]), 32'h1);
         end
      end
      check("ch0_rise_latency", rise_at, 5);
      check("ch0_rise_count", rise_cnt, 1);
      check("ch0_flag", 32'(bus.o_flag[0]), 32'h1);
      check("ch0_any", 32'(bus.o_any), 32'h1);
      bus.flag_clr = 8'hFF;
      cycle("clr0");
      bus.flag_clr = '0;

      // ch1 2-cycle glitch must be fully suppressed
      hit = 0;
      bus.signal[1] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) bus.signal[1] = 1'b0;
         cycle("ch1");
         if (bus.o_level[1] | bus.o_edge[1] | bus.o_flag[1]) hit++;
      end
      check("ch1_glitch_activity", hit, 0);

      // ch2 rise disabled, fall enabled
      rise_cnt = 0;
      fall_cnt = 0;
      bus.signal[2] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin
            check("ch2_level_high", 32'(bus.o_level[2]), 32'h1);
            bus.signal[2] = 1'b0;
         end
         cycle("ch2");
         if (bus.o_rise[2]) rise_cnt++;
         if (bus.o_fall[2]) fall_cnt++;
      end
      check("ch2_rise_count", rise_cnt, 0);
      check("ch2_fall_count", fall_cnt, 1);
      check("ch2_level_low", 32'(bus.o_level[2]), 32'h0);

      // ch3 clear coinciding with a new edge: set wins
      bus.signal[3] = 1'b1;
      for (int i = 0; i < 8; i++) cycle("ch3_up");
      bus.flag_clr = 8'hFF;
      cycle("ch3_clr_all");
      bus.flag_clr  = '0;
      bus.signal[3] = 1'b0;
      for (int i = 0; i < 4; i++) cycle("ch3_dn");
      bus.flag_clr[3] = 1'b1;
      cycle("ch3_coincide");
      check("ch3_fall_on_clr", 32'(bus.o_fall[3]), 32'h1);
      check("ch3_flag_set_wins", 32'(bus.o_flag[3]), 32'h1);
      bus.flag_clr[3] = 1'b0;
      cycle("ch3_hold");
      bus.flag_clr[3] = 1'b1;
      cycle("ch3_clear");
      bus.flag_clr[3] = 1'b0;
      check("ch3_flag_cleared", 32'(bus.o_flag[3]), 32'h0);
      check("ch3_any_dropped", 32'(bus.o_any), 32'h0);

      // randomized traffic with random modes and clears
      bus.signal = $urandom();
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < W; c++)
            if ($urandom_range(0, 5) == 0) bus.signal[c] = ~bus.signal[c];
         bus.mode_rise = $urandom();
         bus.mode_fall = $urandom();
         bus.flag_clr  = ($urandom_range(0, 3) == 0) ? W'($urandom()) : '0;
         cycle("rand");
      end

      // asynchronous reset mid-filter with the input held high
      bus.mode_rise = 8'hFF;
      bus.mode_fall = 8'hFF;
      bus.flag_clr  = '0;
      bus.signal    = 8'h60;
      for (int i = 0; i < 10; i++) cycle("pre_rst");
      bus.signal[4] = 1'b1;
      for (int i = 0; i < 4; i++) cycle("mid_filt");
      #2 rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n    = 1'b1;
      rise_at  = 0;
      rise_cnt = 0;
      mask     = '0;
      for (int i = 1; i <= 10; i++) begin
         cycle("post_rst");
         if (bus.o_rise[4]) begin
            rise_cnt++;
            rise_at = i;
            mask    = bus.o_rise;
         end
      end
      check("rst_rise_latency", rise_at, 5);
      check("rst_rise_count", rise_cnt, 1);
      check("rst_rise_mask", 32'(mask), 32'h70);

      // all channels toggle together
      bus.signal   = '0;
      bus.flag_clr = 8'hFF;
      for (int i = 0; i < 8; i++) cycle("all_low");
      bus.flag_clr = '0;
      bus.signal   = 8'hFF;
      hit     = 0;
      rise_at = 0;
      for (int i = 1; i <= 10; i++) begin
         cycle("all_up");
         if (bus.o_edge == 8'hFF) begin
            hit++;
            rise_at = i;
            check("all_rise_mask", 32'(bus.o_rise), 32'hFF);
         end
      end
      check("all_edge_count", hit, 1);
      check("all_edge_latency", rise_at, 5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
